pipeline_stall_ctrl: RTL and testbench
======================================

Name: pipeline_stall_ctrl

Overview:
- Consumer end of the hazard/stall path in the 5-stage RISC-V pipeline.
- Takes the load-use `stall` from hazard_detection_unit, `branch_taken` from EX and `mem_busy` from data memory.
- Drives per-stage write-enable and flush controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Sequences multi-cycle flush and memory-wait episodes with a small FSM.

Parameters:
- FLUSH_CYCLES, 2, total cycles IF/ID and ID/EX are squashed after a taken branch (≥1).
- CNT_W, 32, width of performance counters.

Ports:
- clk  input  1  pipeline clock.
- rst_n  input  1  asynchronous active-low reset.
- stall  input  1  load-use stall request from hazard_detection_unit.
- branch_taken  input  1  taken branch/jump resolved in EX this cycle.
- mem_busy  input  1  data memory not ready; whole pipeline must freeze.
- pc_write  output  1  PC update enable.
- ifid_write  output  1  IF/ID register enable.
- ifid_flush  output  1  zero IF/ID (insert NOP).
- idex_write  output  1  ID/EX register enable.
- idex_flush  output  1  zero ID/EX control (bubble).
- exmem_write  output  1  EX/MEM register enable.
- memwb_write  output  1  MEM/WB register enable.
- ctrl_state  output  2  current FSM state, for debug.
- stall_cnt, flush_cnt, memwait_cnt  output  CNT_W each  performance counters.

Behaviour:
- States: RESET=0, RUN=1, FLUSH=2, MEM_WAIT=3.
- Outputs are a combinational (Mealy) decode of state and inputs, so a stall takes effect in the same cycle it is raised. State and counters are registered.
- Async reset: state=RESET, flush_left=0, counters=0.
- RESET, one cycle after rst_n rises:
  - pc_write=0; all other writes=1; ifid_flush=idex_flush=1.
  - Next state RUN. Inputs are ignored.
- RUN, evaluated in priority order:
  - mem_busy=1: all *_write=0, no flush; next MEM_WAIT, flush_left unchanged.
  - else branch_taken=1: pc_write=1 (redirect); ifid_write=idex_write=1; ifid_flush=idex_flush=1.
    - FLUSH_CYCLES=1: stay RUN.
    - Otherwise: flush_left=FLUSH_CYCLES-1, next FLUSH.
    - Any coincident stall is dropped, because the younger instruction is squashed.
  - else stall=1: pc_write=0, ifid_write=0, idex_flush=1, others write=1; stay RUN. A 1-cycle stall requires no state change.
  - else: all writes=1, flushes=0.
- FLUSH:
  - mem_busy=1: freeze as in RUN; next MEM_WAIT, flush_left held.
  - else branch_taken=1: reload flush_left=FLUSH_CYCLES-1 with RUN branch outputs.
  - else: pc_write=1, all writes=1, ifid_flush=idex_flush=1.
    - flush_left decrements.
    - When flush_left==1 before decrement, next RUN.
  - stall is ignored in FLUSH.
- MEM_WAIT:
  - All *_write=0, flushes=0; stall and branch_taken ignored (held stages re-present them).
  - On mem_busy=0: same-cycle outputs are as in RUN with mem_busy=0. Next state is FLUSH if flush_left>0, else RUN.
- Reset mid-episode: immediate return to RESET. No partial flush is resumed.

Optional Feature:
- STALL_PERF_EN.
- Defined: counters increment once per cycle, wrapping at 2^CNT_W.
  - stall_cnt: RUN with effective stall.
  - flush_cnt: any cycle with idex_flush=1 outside RESET.
  - memwait_cnt: cycles in MEM_WAIT or entering it.
- Undefined: counters are not implemented; the ports are tied to 0.

Decomposition:
- Shared package pipe_ctrl_pkg: state encoding constants (ST_RESET, ST_RUN, ST_FLUSH, ST_MEM_WAIT) and the default FLUSH_CYCLES.
- One natural sub-module: perf_counter (enable, wrap, CNT_W parameter), instantiated 3× under STALL_PERF_EN.

Test Plan:
- Reset, release rst_n: cycle 1 pc_write=0, ifid_flush=idex_flush=1, ctrl_state=0; cycle 2 ctrl_state=1, all writes=1.
- RUN, stall=1 for 1 cycle: pc_write=0, ifid_write=0, idex_flush=1 that cycle; next cycle all writes=1; stall_cnt=1 (with STALL_PERF_EN).
- branch_taken=1 and stall=1 together, FLUSH_CYCLES=2: that cycle flushes=1, pc_write=1; next cycle ctrl_state=2, flushes=1; third cycle RUN, flushes=0; flush_cnt=2.
- mem_busy=1 for 3 cycles during RUN: all *_write=0 for 3 cycles, ctrl_state=3 for 2 cycles; on release all writes=1; memwait_cnt=3.
- Branch, then mem_busy=1 during FLUSH (FLUSH_CYCLES=3, flush_left=2): freeze 2 cycles, then 2 flush cycles resume, then RUN.
- rst_n pulsed low mid-FLUSH: outputs immediately reflect RESET; counters=0; no residual flush after RESET→RUN.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller: FSM state
// encoding, the per-stage control bundle and its canned settings.
package pipe_ctrl_pkg;

   // Debug-visible encoding; ctrl_state exposes these values directly.
   typedef enum logic [1:0] {
      ST_RESET    = 2'd0,
      ST_RUN      = 2'd1,
      ST_FLUSH    = 2'd2,
      ST_MEM_WAIT = 2'd3
   } ctrl_state_e;

   localparam int FLUSH_CYCLES_DEFAULT = 2;

   // One bundle for every per-stage enable/flush so each decode branch
   // assigns the whole set at once and nothing is left undriven.
   typedef struct packed {
      logic pc_write;
      logic ifid_write;
      logic ifid_flush;
      logic idex_write;
      logic idex_flush;
      logic exmem_write;
      logic memwb_write;
   } stage_ctrl_t;

   // Whole pipeline held, nothing squashed (memory not ready).
   localparam stage_ctrl_t CTRL_FREEZE = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0,
                                          idex_write: 1'b0, idex_flush: 1'b0,
                                          exmem_write: 1'b0, memwb_write: 1'b0};
   // Normal advance.
   localparam stage_ctrl_t CTRL_RUN    = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b0,
                                          idex_write: 1'b1, idex_flush: 1'b0,
                                          exmem_write: 1'b1, memwb_write: 1'b1};
   // Load-use: hold PC and IF/ID, bubble into ID/EX, older stages drain.
   localparam stage_ctrl_t CTRL_STALL  = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0,
                                          idex_write: 1'b1, idex_flush: 1'b1,
                                          exmem_write: 1'b1, memwb_write: 1'b1};
   // Branch redirect or flush episode: PC moves, front end squashed.
   localparam stage_ctrl_t CTRL_SQUASH = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b1,
                                          idex_write: 1'b1, idex_flush: 1'b1,
                                          exmem_write: 1'b1, memwb_write: 1'b1};
   // First cycle after reset: PC stays on the reset vector, front end cleared.
   localparam stage_ctrl_t CTRL_RESET  = '{pc_write: 1'b0, ifid_write: 1'b1, ifid_flush: 1'b1,
                                          idex_write: 1'b1, idex_flush: 1'b1,
                                          exmem_write: 1'b1, memwb_write: 1'b1};

endpackage

// File: rtl/perf_counter.sv
// Free-running event counter: increments by one on each enabled cycle and
// wraps naturally at 2^CNT_W.
module perf_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en_i,
   output logic [CNT_W-1:0] count_o
);

   logic [CNT_W-1:0] count_q;

   // Count enabled cycles; wrap is the natural modulo of the adder.
   // NOTE: sequential state uses <= so every flop samples pre-edge values,
   // and the async reset sits in the sensitivity list so it acts without a clock.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else if (en_i) begin
         count_q <= count_q + CNT_W'(1);
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Pipeline stall/flush controller for the 5-stage RISC-V core.
// Turns load-use stall, taken-branch and data-memory-busy requests into
// per-stage write enables and flushes. Outputs are a Mealy decode of the
// registered FSM state, so a request acts in the cycle it is raised.
// Optional build macro STALL_PERF_EN adds stall/flush/memory-wait counters;
// without it the counter ports are tied to zero.
module pipeline_stall_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEFAULT,
   parameter int CNT_W        = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             stall,
   input  logic             branch_taken,
   input  logic             mem_busy,
   output logic             pc_write,
   output logic             ifid_write,
   output logic             ifid_flush,
   output logic             idex_write,
   output logic             idex_flush,
   output logic             exmem_write,
   output logic             memwb_write,
   output logic [1:0]       ctrl_state,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt,
   output logic [CNT_W-1:0] memwait_cnt
);

   // flush_left only ever holds FLUSH_CYCLES-1 down to 0.
   localparam int              FL_W      = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam logic [FL_W-1:0] FL_RELOAD = FL_W'(FLUSH_CYCLES - 1);

   ctrl_state_e     state_q, state_d;
   logic [FL_W-1:0] flush_left_q, flush_left_d;
   stage_ctrl_t     ctrl;

   // Decode stage controls and next state from current state and requests.
   // NOTE: every variable gets a default at the top so no path can infer a latch.
   always_comb begin
      ctrl         = CTRL_FREEZE;
      state_d      = state_q;
      flush_left_d = flush_left_q;
      unique case (state_q)
         ST_RESET: begin
            ctrl    = CTRL_RESET;
            state_d = ST_RUN;
         end
         // MEM_WAIT on release decodes exactly like RUN; while busy the held
         // stages will re-present stall/branch, so both are ignored here.
         ST_RUN, ST_MEM_WAIT: begin
            if (mem_busy) begin
               ctrl    = CTRL_FREEZE;
               state_d = ST_MEM_WAIT;
            end else if (branch_taken) begin
               // Younger instruction is squashed, so a coincident stall is moot.
               ctrl = CTRL_SQUASH;
               if (FLUSH_CYCLES == 1) begin
                  state_d = ST_RUN;
               end else begin
                  flush_left_d = FL_RELOAD;
                  state_d      = ST_FLUSH;
               end
            end else begin
               ctrl    = stall ? CTRL_STALL : CTRL_RUN;
               // A memory wait that interrupted a flush resumes it afterwards;
               // in RUN flush_left is always zero.
               state_d = (flush_left_q != '0) ? ST_FLUSH : ST_RUN;
            end
         end
         ST_FLUSH: begin
            if (mem_busy) begin
               ctrl    = CTRL_FREEZE;
               state_d = ST_MEM_WAIT;
            end else if (branch_taken) begin
               ctrl         = CTRL_SQUASH;
               flush_left_d = FL_RELOAD;
               state_d      = ST_FLUSH;
            end else begin
               ctrl         = CTRL_SQUASH;
               flush_left_d = flush_left_q - FL_W'(1);
               state_d      = (flush_left_q == FL_W'(1)) ? ST_RUN : ST_FLUSH;
            end
         end
      endcase
   end

   // FSM state and remaining flush count; reset abandons any episode.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_RESET;
         flush_left_q <= '0;
      end else begin
         state_q      <= state_d;
         flush_left_q <= flush_left_d;
      end
   end

   assign pc_write    = ctrl.pc_write;
   assign ifid_write  = ctrl.ifid_write;
   assign ifid_flush  = ctrl.ifid_flush;
   assign idex_write  = ctrl.idex_write;
   assign idex_flush  = ctrl.idex_flush;
   assign exmem_write = ctrl.exmem_write;
   assign memwb_write = ctrl.memwb_write;
   assign ctrl_state  = state_q;

`ifdef STALL_PERF_EN
   logic stall_inc, flush_inc, memwait_inc;

   // Effective stall: stall decode actually applied while running.
   assign stall_inc   = (state_q == ST_RUN) && !mem_busy && !branch_taken && stall;
   assign flush_inc   = ctrl.idex_flush && (state_q != ST_RESET);
   // Frozen cycles: the one entering MEM_WAIT plus each one spent waiting.
   assign memwait_inc = mem_busy && (state_q != ST_RESET);

   perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk    (clk),
      .rst_n  (rst_n),
      .en_i   (stall_inc),
      .count_o(stall_cnt)
   );

   perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk    (clk),
      .rst_n  (rst_n),
      .en_i   (flush_inc),
      .count_o(flush_cnt)
   );

   perf_counter #(.CNT_W(CNT_W)) u_memwait_cnt (
      .clk    (clk),
      .rst_n  (rst_n),
      .en_i   (memwait_inc),
      .count_o(memwait_cnt)
   );
`else
   assign stall_cnt   = {CNT_W{1'b0}};
   assign flush_cnt   = {CNT_W{1'b0}};
   assign memwait_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Self-checking bench for pipeline_stall_ctrl: a directed vector table on a
// FLUSH_CYCLES=2 instance, then hand sequences for reset mid-flush and a
// memory wait interrupting a FLUSH_CYCLES=3 flush.
module tb_pipeline_stall_ctrl;

`ifdef STALL_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   // Expected controls packed as {pc_w, ifid_w, ifid_f, idex_w, idex_f, exmem_w, memwb_w}.
   localparam logic [6:0] E_RESET  = 7'b0111111;
   localparam logic [6:0] E_RUN    = 7'b1101011;
   localparam logic [6:0] E_STALL  = 7'b0001111;
   localparam logic [6:0] E_SQUASH = 7'b1111111;
   localparam logic [6:0] E_FREEZE = 7'b0000000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stall = 1'b0, branch_taken = 1'b0, mem_busy = 1'b0;

   logic        pc_w, ifid_w, ifid_f, idex_w, idex_f, exmem_w, memwb_w;
   logic [1:0]  st;
   logic [31:0] s_cnt, f_cnt, m_cnt;

   logic        pc_w3, ifid_w3, ifid_f3, idex_w3, idex_f3, exmem_w3, memwb_w3;
   logic [1:0]  st3;
   logic [31:0] s_cnt3, f_cnt3, m_cnt3;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pipeline_stall_ctrl #(.FLUSH_CYCLES(2), .CNT_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .branch_taken(branch_taken), .mem_busy(mem_busy),
      .pc_write(pc_w), .ifid_write(ifid_w), .ifid_flush(ifid_f), .idex_write(idex_w),
      .idex_flush(idex_f), .exmem_write(exmem_w), .memwb_write(memwb_w), .ctrl_state(st),
      .stall_cnt(s_cnt), .flush_cnt(f_cnt), .memwait_cnt(m_cnt)
   );

   pipeline_stall_ctrl #(.FLUSH_CYCLES(3), .CNT_W(32)) dut3 (
      .clk(clk), .rst_n(rst_n), .stall(stall), .branch_taken(branch_taken), .mem_busy(mem_busy),
      .pc_write(pc_w3), .ifid_write(ifid_w3), .ifid_flush(ifid_f3), .idex_write(idex_w3),
      .idex_flush(idex_f3), .exmem_write(exmem_w3), .memwb_write(memwb_w3), .ctrl_state(st3),
      .stall_cnt(s_cnt3), .flush_cnt(f_cnt3), .memwait_cnt(m_cnt3)
   );

   typedef struct {
      string      name;
      logic       stall;
      logic       br;
      logic       mb;
      logic [6:0] exp_ctrl;
      logic [1:0] exp_state;
   } vec_t;

   vec_t vecs[19];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [6:0] ctrl2();
      return {pc_w, ifid_w, ifid_f, idex_w, idex_f, exmem_w, memwb_w};
   endfunction

   function automatic logic [6:0] ctrl3();
      return {pc_w3, ifid_w3, ifid_f3, idex_w3, idex_f3, exmem_w3, memwb_w3};
   endfunction

   // Drive inputs just after a rising edge and sample mid-cycle at the falling edge.
   task automatic apply(input logic s, input logic b, input logic m);
      stall = s; branch_taken = b; mem_busy = m;
      @(negedge clk);
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      vecs[0]  = '{"reset_cycle",      1'b0, 1'b0, 1'b0, E_RESET,  2'd0};
      vecs[1]  = '{"run_idle",         1'b0, 1'b0, 1'b0, E_RUN,    2'd1};
      vecs[2]  = '{"stall_1cyc",       1'b1, 1'b0, 1'b0, E_STALL,  2'd1};
      vecs[3]  = '{"after_stall",      1'b0, 1'b0, 1'b0, E_RUN,    2'd1};
      vecs[4]  = '{"branch_and_stall", 1'b1, 1'b1, 1'b0, E_SQUASH, 2'd1};
      vecs[5]  = '{"flush_ign_stall",  1'b1, 1'b0, 1'b0, E_SQUASH, 2'd2};
      vecs[6]  = '{"flush_done",       1'b0, 1'b0, 1'b0, E_RUN,    2'd1};
      vecs[7]  = '{"mem_busy_enter",   1'b0, 1'b0, 1'b1, E_FREEZE, 2'd1};
      vecs[8]  = '{"mem_wait_stall",   1'b1, 1'b0, 1'b1, E_FREEZE, 2'd3};
      vecs[9]  = '{"mem_wait_branch",  1'b0, 1'b1, 1'b1, E_FREEZE, 2'd3};
      vecs[10] = '{"mem_release",      1'b0, 1'b0, 1'b0, E_RUN,    2'd3};
      vecs[11] = '{"run_after_wait",   1'b0, 1'b0, 1'b0, E_RUN,    2'd1};
      vecs[12] = '{"branch_2",         1'b0, 1'b1, 1'b0, E_SQUASH, 2'd1};
      vecs[13] = '{"branch_in_flush",  1'b0, 1'b1, 1'b0, E_SQUASH, 2'd2};
      vecs[14] = '{"reloaded_flush",   1'b0, 1'b0, 1'b0, E_SQUASH, 2'd2};
      vecs[15] = '{"run_after_reload", 1'b0, 1'b0, 1'b0, E_RUN,    2'd1};
      vecs[16] = '{"stall_2cyc_a",     1'b1, 1'b0, 1'b0, E_STALL,  2'd1};
      vecs[17] = '{"stall_2cyc_b",     1'b1, 1'b0, 1'b0, E_STALL,  2'd1};
      vecs[18] = '{"after_stall_2",    1'b0, 1'b0, 1'b0, E_RUN,    2'd1};

      // Held in reset: FSM parked in RESET, counters clear.
      repeat (2) @(posedge clk);
      #1;
      check("in_reset_state", 32'(st), 32'd0);
      check("in_reset_ctrl", 32'(ctrl2()), 32'(E_RESET));
      check("in_reset_flush_cnt", f_cnt, 32'd0);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         apply(vecs[i].stall, vecs[i].br, vecs[i].mb);
         check({vecs[i].name, "_ctrl"}, 32'(ctrl2()), 32'(vecs[i].exp_ctrl));
         check({vecs[i].name, "_state"}, 32'(st), 32'(vecs[i].exp_state));
         if (i == 3) check("stall_cnt_after_1", s_cnt, PERF ? 32'd1 : 32'd0);
         if (i == 6) check("flush_cnt_after_branch", f_cnt, PERF ? 32'd3 : 32'd0);
         if (i == 11) check("memwait_cnt_after_wait", m_cnt, PERF ? 32'd3 : 32'd0);
         next_cycle();
      end

      check("stall_cnt_total", s_cnt, PERF ? 32'd3 : 32'd0);
      check("flush_cnt_total", f_cnt, PERF ? 32'd8 : 32'd0);
      check("memwait_cnt_total", m_cnt, PERF ? 32'd3 : 32'd0);

      // Reset pulsed mid-FLUSH: immediate RESET decode, counters cleared,
      // and no leftover flush once back in RUN.
      apply(1'b0, 1'b1, 1'b0);
      check("pre_reset_branch", 32'(ctrl2()), 32'(E_SQUASH));
      next_cycle();
      apply(1'b0, 1'b0, 1'b0);
      check("pre_reset_in_flush", 32'(st), 32'd2);
      next_cycle();
      rst_n = 1'b0;
      #1;
      check("midflush_rst_state", 32'(st), 32'd0);
      check("midflush_rst_ctrl", 32'(ctrl2()), 32'(E_RESET));
      check("midflush_rst_flush_cnt", f_cnt, 32'd0);
      check("midflush_rst_stall_cnt", s_cnt, 32'd0);
      next_cycle();
      rst_n = 1'b1;
      apply(1'b0, 1'b0, 1'b0);
      check("rerelease_ctrl", 32'(ctrl2()), 32'(E_RESET));
      next_cycle();
      apply(1'b0, 1'b0, 1'b0);
      check("no_residual_flush_ctrl", 32'(ctrl2()), 32'(E_RUN));
      check("no_residual_flush_state", 32'(st), 32'd1);
      next_cycle();

      // FLUSH_CYCLES=3: branch, memory wait interrupts the flush with two
      // cycles left, flush resumes after the release cycle, then RUN.
      apply(1'b0, 1'b1, 1'b0);
      check("fc3_branch_ctrl", 32'(ctrl3()), 32'(E_SQUASH));
      check("fc3_branch_state", 32'(st3), 32'd1);
      next_cycle();
      apply(1'b0, 1'b0, 1'b1);
      check("fc3_freeze1_ctrl", 32'(ctrl3()), 32'(E_FREEZE));
      check("fc3_freeze1_state", 32'(st3), 32'd2);
      next_cycle();
      apply(1'b1, 1'b1, 1'b1);
      check("fc3_freeze2_ctrl", 32'(ctrl3()), 32'(E_FREEZE));
      check("fc3_freeze2_state", 32'(st3), 32'd3);
      next_cycle();
      apply(1'b0, 1'b0, 1'b0);
      check("fc3_release_ctrl", 32'(ctrl3()), 32'(E_RUN));
      check("fc3_release_state", 32'(st3), 32'd3);
      next_cycle();
      for (int k = 0; k < 2; k++) begin
         apply(1'b0, 1'b0, 1'b0);
         check($sformatf("fc3_resume%0d_ctrl", k), 32'(ctrl3()), 32'(E_SQUASH));
         check($sformatf("fc3_resume%0d_state", k), 32'(st3), 32'd2);
         next_cycle();
      end
      apply(1'b0, 1'b0, 1'b0);
      check("fc3_back_run_ctrl", 32'(ctrl3()), 32'(E_RUN));
      check("fc3_back_run_state", 32'(st3), 32'd1);
      next_cycle();
      check("fc3_flush_cnt", f_cnt3, PERF ? 32'd3 : 32'd0);
      check("fc3_memwait_cnt", m_cnt3, PERF ? 32'd2 : 32'd0);
      check("fc3_stall_cnt", s_cnt3, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
